// File: rtl/dpll_pkg.sv
// Shared types and constants for the delay-line PLL lock controller.
package dpll_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALIGN   = 2'd1,
        MEASURE = 2'd2,
        UPDATE  = 2'd3
    } state_t;

endpackage

// File: rtl/dpll_lock_ctrl_if.sv
// Control/status bundle between the pad-side driver and the lock controller.
interface dpll_lock_ctrl_if #(
    parameter int CODE_W = 6,
    parameter int CNT_W  = 10
) ();

    logic              en;
    logic [CNT_W-1:0]  target;
    logic              ref_in;
    logic              fb_in;
    logic [CODE_W-1:0] code_out;
    logic              locked;
    logic              win_done;
    logic [CNT_W-1:0]  fb_count;
    logic              coarse;

    modport master (
        output en, target, ref_in, fb_in,
        input  code_out, locked, win_done, fb_count, coarse
    );

    modport slave (
        input  en, target, ref_in, fb_in,
        output code_out, locked, win_done, fb_count, coarse
    );

endinterface

// File: rtl/dpll_lock_ctrl_edge_sync.sv
// Brings an asynchronous 1-bit input into clk and emits a one-cycle pulse per rising edge.
module edge_sync
    import dpll_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Pulse is consumed on the third edge after the input transition.
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/dpll_lock_ctrl.sv
// Frequency-lock loop: counts feedback edges per reference window and steers the
// delay-line code with a binary search followed by +/-1 tracking.
module dpll_lock_ctrl
    import dpll_pkg::*;
#(
    parameter int CODE_W   = 6,
    parameter int CNT_W    = 10,
    parameter int WIN_REFS = 4,
    parameter int TOL      = 1,
    parameter int LOCK_WIN = 4
) (
    input logic              clk,
    input logic              rst,
    dpll_lock_ctrl_if.slave  bus
);

    localparam int REF_W = (WIN_REFS > 1) ? $clog2(WIN_REFS) : 1;
    localparam int RUN_W = $clog2(LOCK_WIN + 1);

    localparam logic [CODE_W-1:0]       CODE_MID  = CODE_W'(1 << (CODE_W - 1));
    localparam logic [CODE_W-1:0]       STEP_ONE  = CODE_W'(1);
    localparam logic [CNT_W-1:0]        CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [REF_W-1:0]        LAST_REF  = REF_W'(WIN_REFS - 1);
    localparam logic [RUN_W-1:0]        RUN_FULL  = RUN_W'(LOCK_WIN);
    localparam logic signed [CNT_W:0]   TOL_POS   = (CNT_W + 1)'(TOL);
    localparam logic signed [CNT_W:0]   TOL_NEG   = (CNT_W + 1)'(-TOL);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_target;
    logic [REF_W-1:0]   r_refs;
    logic [CODE_W-1:0]  r_step;
    logic [CODE_W-1:0]  r_code;
    logic [RUN_W-1:0]   r_run;
    logic               r_locked;
    logic               r_win_done;
    logic [CNT_W-1:0]   r_fb_count;
    logic               r_coarse;

    logic               w_ref_rise;
    logic               w_fb_rise;

    edge_sync u_ref_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.ref_in),
        .o_rise  (w_ref_rise)
    );

    edge_sync u_fb_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.fb_in),
        .o_rise  (w_fb_rise)
    );

    logic signed [CNT_W:0] w_diff;
    logic                  w_above;
    logic                  w_below;
    logic                  w_inband;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [CODE_W-1:0]     w_step_app;
    logic [CODE_W:0]       w_code_up;
    logic [CODE_W-1:0]     w_code_sat_up;
    logic [CODE_W-1:0]     w_code_sat_dn;
    logic [RUN_W-1:0]      w_run_inc;

    assign w_diff    = $signed({1'b0, r_cnt}) - $signed({1'b0, r_target});
    assign w_above   = (w_diff > TOL_POS);
    assign w_below   = (w_diff < TOL_NEG);
    assign w_inband  = ~w_above & ~w_below;
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // The stored step starts at half-scale; each coarse update applies half of it,
    // so the first move from mid-code is a quarter of the range.
    assign w_step_app    = (r_coarse && r_step > STEP_ONE) ? (r_step >> 1) : STEP_ONE;
    assign w_code_up     = {1'b0, r_code} + {1'b0, w_step_app};
    assign w_code_sat_up = w_code_up[CODE_W] ? {CODE_W{1'b1}} : w_code_up[CODE_W-1:0];
    assign w_code_sat_dn = (r_code < w_step_app) ? '0 : r_code - w_step_app;
    assign w_run_inc     = (r_run == RUN_FULL) ? r_run : r_run + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_target   <= '0;
            r_refs     <= '0;
            r_step     <= CODE_MID;
            r_code     <= CODE_MID;
            r_run      <= '0;
            r_locked   <= 1'b0;
            r_win_done <= 1'b0;
            r_fb_count <= '0;
            r_coarse   <= 1'b1;
        end else begin
            r_win_done <= 1'b0;
            if (!bus.en) begin
                // Any partial window is simply abandoned; the code is left where it was.
                r_state  <= IDLE;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state  <= ALIGN;
                        r_step   <= CODE_MID;
                        r_coarse <= 1'b1;
                        r_run    <= '0;
                    end
                    ALIGN: begin
                        if (w_ref_rise) begin
                            r_cnt    <= '0;
                            r_target <= bus.target;
                            r_refs   <= '0;
                            r_state  <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (w_fb_rise) begin
                            r_cnt <= w_cnt_inc;
                        end
                        if (w_ref_rise) begin
                            if (r_refs == LAST_REF) begin
                                r_state <= UPDATE;
                            end else begin
                                r_refs <= r_refs + 1'b1;
                            end
                        end
                    end
                    UPDATE: begin
                        r_state    <= ALIGN;
                        r_win_done <= 1'b1;
                        r_fb_count <= r_cnt;
                        if (w_above) begin
                            r_code <= w_code_sat_up;
                        end else if (w_below) begin
                            r_code <= w_code_sat_dn;
                        end
                        if (r_coarse) begin
                            if (w_inband || w_step_app == STEP_ONE) begin
                                r_coarse <= 1'b0;
                                r_step   <= STEP_ONE;
                            end else begin
                                r_step <= w_step_app;
                            end
                        end
                        // Coarse-phase hits do not count toward lock.
                        if (!w_inband) begin
                            r_run    <= '0;
                            r_locked <= 1'b0;
                        end else if (!r_coarse) begin
                            r_run    <= w_run_inc;
                            r_locked <= (w_run_inc == RUN_FULL);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.code_out = r_code;
    assign bus.locked   = r_locked;
    assign bus.win_done = r_win_done;
    assign bus.fb_count = r_fb_count;
    assign bus.coarse   = r_coarse;

endmodule

// File: tb/tb_dpll_lock_ctrl.sv
// Randomised window-level stimulus with a behavioural loop model and a win_done-driven scoreboard.
module tb_dpll_lock_ctrl;

    localparam int CODE_W   = 6;
    localparam int CNT_W    = 10;
    localparam int WIN_REFS = 4;
    localparam int TOL      = 1;
    localparam int LOCK_WIN = 4;
    localparam int CODE_MAX = (1 << CODE_W) - 1;
    localparam int P        = 64;                     // ref period in clk cycles
    localparam int CLOSE_T  = WIN_REFS * P;           // closing ref rise, relative to opening
    localparam int TR_LEN   = (WIN_REFS + 1) * P;     // one full loop period

    logic clk = 1'b0;
    logic rst;

    dpll_lock_ctrl_if #(.CODE_W(CODE_W), .CNT_W(CNT_W)) bus ();

    dpll_lock_ctrl #(
        .CODE_W   (CODE_W),
        .CNT_W    (CNT_W),
        .WIN_REFS (WIN_REFS),
        .TOL      (TOL),
        .LOCK_WIN (LOCK_WIN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int code;
        int cnt;
        int locked;
        int coarse;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_txn  = 0;

    // Behavioural loop model
    int m_code   = 32;
    int m_step   = 32;
    int m_coarse = 1;
    int m_run    = 0;
    int m_locked = 0;
    int m_target = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Oscillator: frequency inversely proportional to (code+8); code 20 yields 40 edges.
    function automatic int plant_count(input int code);
        int c;
        c = (1120 + (code + 8) / 2) / (code + 8);
        return (c > 60) ? 60 : c;
    endfunction

    task automatic model_window(input int cnt);
        int d;
        int st;
        bit inb;
        bit was_coarse;
        d          = cnt - m_target;
        inb        = (d <= TOL) && (d >= -TOL);
        was_coarse = (m_coarse != 0);
        st         = was_coarse ? m_step / 2 : 1;
        if (d > TOL)       m_code = (m_code + st > CODE_MAX) ? CODE_MAX : m_code + st;
        else if (d < -TOL) m_code = (m_code - st < 0) ? 0 : m_code - st;
        if (was_coarse) begin
            m_step = st;
            if (inb || st == 1) begin
                m_coarse = 0;
                m_step   = 1;
            end
        end
        if (!inb)                                 m_run = 0;
        else if (!was_coarse && m_run < LOCK_WIN) m_run = m_run + 1;
        m_locked = (m_run == LOCK_WIN) ? 1 : 0;
        sb_q.push_back('{code: m_code, cnt: cnt, locked: m_locked, coarse: m_coarse});
    endtask

    task automatic model_restart();
        m_step   = 32;
        m_coarse = 1;
        m_run    = 0;
        m_locked = 0;
    endtask

    // One loop period starting at an opening ref rise. nfb feedback rises land in
    // (opening, closing]; extra noise rises go where the controller must ignore them.
    task automatic run_window(input int nfb, input bit force_close, input bit expect_result,
                              input int drop_en_at);
        bit rise [TR_LEN];
        int need;
        int avail;
        bit fbv;
        for (int t = 0; t < TR_LEN; t++) rise[t] = 1'b0;
        need  = nfb;
        avail = 64;
        if (force_close) begin
            rise[CLOSE_T] = 1'b1;
            need--;
            avail = 63;
        end
        for (int k = 1; k <= avail; k++) begin
            if (need > 0 && int'($urandom_range(avail - k)) < need) begin
                rise[4 * k] = 1'b1;
                need--;
            end
        end
        if (nfb > 0) begin
            rise[0] = 1'($urandom_range(1));
            for (int t = CLOSE_T + 4; t <= TR_LEN - 4; t += 4) rise[t] = 1'($urandom_range(1));
        end
        if (expect_result) model_window(nfb);
        for (int t = 0; t < TR_LEN; t++) begin
            @(posedge clk);
            #1;
            fbv         = rise[t] || (t > 0 && rise[t - 1]);
            bus.ref_in  = ((t % P) < (P / 2));
            bus.fb_in   = fbv;
            if (t == drop_en_at) bus.en = 1'b0;
            if (drop_en_at >= 0 && t == drop_en_at + 3) begin
                check("disable_locked", int'(bus.locked), 0);
                check("disable_code_held", int'(bus.code_out), m_code);
            end
        end
        @(negedge clk);
        check("window_drained", sb_q.size(), 0);
    endtask

    task automatic restart_loop();
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.en = 1'b1;
        repeat (10) @(posedge clk);
        model_restart();
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.win_done === 1'b1) begin
                check("win_done_expected", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    n_txn++;
                    $display("txn %0d: fb_count=%0d code=%0d locked=%0d coarse=%0d (exp %0d/%0d/%0d/%0d)",
                             n_txn, bus.fb_count, bus.code_out, bus.locked, bus.coarse,
                             e.cnt, e.code, e.locked, e.coarse);
                    check("fb_count", int'(bus.fb_count), e.cnt);
                    check("code_out", int'(bus.code_out), e.code);
                    check("locked", int'(bus.locked), e.locked);
                    check("coarse", int'(bus.coarse), e.coarse);
                end
            end
        end
    end

    initial begin
        int exp_codes  [4];
        int exp_coarse [4];
        exp_codes  = '{16, 24, 20, 20};
        exp_coarse = '{1, 1, 1, 0};

        rst        = 1'b1;
        bus.en     = 1'b0;
        bus.target = '0;
        bus.ref_in = 1'b0;
        bus.fb_in  = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_code", int'(bus.code_out), 32);
        check("reset_locked", int'(bus.locked), 0);
        check("reset_coarse", int'(bus.coarse), 1);
        check("reset_win_done", int'(bus.win_done), 0);
        check("reset_fb_count", int'(bus.fb_count), 0);

        // Enabled with no reference edges: nothing may move
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.en     = 1'b1;
        bus.target = CNT_W'(40);
        m_target   = 40;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("noref_code", int'(bus.code_out), 32);
        check("noref_coarse", int'(bus.coarse), 1);
        check("noref_locked", int'(bus.locked), 0);
        check("noref_fb_count", int'(bus.fb_count), 0);

        // Binary search toward code 20, then four fine in-band windows to lock
        for (int w = 0; w < 8; w++) begin
            run_window(plant_count(m_code), 1'b0, 1'b1, -1);
            if (w < 4) begin
                check("search_code", int'(bus.code_out), exp_codes[w]);
                check("search_coarse", int'(bus.coarse), exp_coarse[w]);
            end
            if (w == 6) check("lock_not_early", int'(bus.locked), 0);
            if (w == 7) check("lock_after_4", int'(bus.locked), 1);
        end

        // Lock loss: count = target+3 must step the code up by one and drop lock
        run_window(m_target + 3, 1'b0, 1'b1, -1);
        check("loss_code", int'(bus.code_out), 21);
        check("loss_locked", int'(bus.locked), 0);
        for (int w = 0; w < 4; w++) run_window(plant_count(m_code), 1'b0, 1'b1, -1);
        check("relock", int'(bus.locked), 1);

        // Feedback edge coincident with the closing reference edge
        run_window(plant_count(m_code), 1'b1, 1'b1, -1);
        run_window(plant_count(m_code), 1'b1, 1'b1, -1);

        // Drop enable mid-measurement: no result, code held, restart in coarse mode
        run_window(plant_count(m_code), 1'b0, 1'b0, 100);
        bus.en = 1'b1;
        repeat (10) @(posedge clk);
        model_restart();
        @(negedge clk);
        check("reenable_coarse", int'(bus.coarse), 1);
        check("reenable_locked", int'(bus.locked), 0);
        bus.target = CNT_W'(60);
        m_target   = 60;
        run_window(plant_count(m_code), 1'b0, 1'b1, -1);
        check("restart_step", int'(bus.code_out), 5);

        // A few random targets
        for (int w = 0; w < 5; w++) begin
            m_target   = int'($urandom_range(20, 60));
            bus.target = CNT_W'(m_target);
            run_window(plant_count(m_code), 1'b0, 1'b1, -1);
        end

        // Saturation at the top code
        restart_loop();
        m_target   = 0;
        bus.target = '0;
        for (int w = 0; w < 40; w++) run_window(plant_count(m_code), 1'b0, 1'b1, -1);
        check("sat_high_code", int'(bus.code_out), CODE_MAX);

        // Saturation at code 0 with the feedback idle
        restart_loop();
        m_target   = 1023;
        bus.target = CNT_W'(1023);
        for (int w = 0; w < 40; w++) run_window(0, 1'b0, 1'b1, -1);
        check("sat_low_code", int'(bus.code_out), 0);
        check("sat_low_fb_count", int'(bus.fb_count), 0);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
